// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // Odd parity: the 8 data bits plus the parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Key-event bus from the PS/2 receiver to the display path.
interface ps2_scancode_rx_if;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_ext;
  logic       code_valid;
  logic       frame_err;

  modport master (output key_code, key_break, key_ext, code_valid, frame_err);
  modport slave  (input  key_code, key_break, key_ext, code_valid, frame_err);
endinterface

// File: rtl/ps2_in_filter.sv
// Pin conditioning: synchronizers on both pins, saturating-count glitch filter
// on ps2_clk, and a one-cycle strobe on the filtered falling edge.
module ps2_in_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_sync
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic [CW-1:0]          cnt;
  logic                   filt;
  logic                   filt_d;

  // Synchronizers idle high, matching an undriven open-collector bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Filtered level flips only after FILTER_LEN consecutive opposite samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      filt   <= 1'b1;
      filt_d <= 1'b1;
    end else begin
      filt_d <= filt;
      if (clk_sync[SYNC_STAGES-1] != filt) begin
        if (cnt == CW'(FILTER_LEN - 1)) begin
          filt <= clk_sync[SYNC_STAGES-1];
          cnt  <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign fall      = filt_d & ~filt;
  assign data_sync = dat_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix folding and timeout.
//
// state  | meaning
// IDLE   | waiting for a start bit
// DATA   | shifting in 8 data bits, LSB first
// PARITY | checking odd parity
// STOP   | checking stop bit, then accepting or flagging the byte
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2_scancode_rx_if.master  bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic fall;
  logic data_s;

  ps2_in_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall     (fall),
    .data_sync(data_s)
  );

  ps2_state_t state_q, state_n;
  logic [7:0]    shift_q, shift_n;
  logic [2:0]    bit_cnt_q, bit_cnt_n;
  logic          par_ok_q, par_ok_n;
  logic          ext_q, ext_n, brk_q, brk_n;
  logic [TW-1:0] tmo_q, tmo_n;
  logic [7:0]    code_q, code_n;
  logic          kbrk_q, kbrk_n, kext_q, kext_n;
  logic          valid_q, valid_n, err_q, err_n;
  logic          timeout;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_ok_q  <= 1'b0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      tmo_q     <= '0;
      code_q    <= '0;
      kbrk_q    <= 1'b0;
      kext_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      shift_q   <= shift_n;
      bit_cnt_q <= bit_cnt_n;
      par_ok_q  <= par_ok_n;
      ext_q     <= ext_n;
      brk_q     <= brk_n;
      tmo_q     <= tmo_n;
      code_q    <= code_n;
      kbrk_q    <= kbrk_n;
      kext_q    <= kext_n;
      valid_q   <= valid_n;
      err_q     <= err_n;
    end
  end

  // Next state, frame checking, prefix folding and timeout; a fall beats a timeout.
  always_comb begin
    state_n   = state_q;
    shift_n   = shift_q;
    bit_cnt_n = bit_cnt_q;
    par_ok_n  = par_ok_q;
    ext_n     = ext_q;
    brk_n     = brk_q;
    tmo_n     = '0;
    code_n    = code_q;
    kbrk_n    = kbrk_q;
    kext_n    = kext_q;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    timeout   = 1'b0;

    if (!fall && state_q != IDLE) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) timeout = 1'b1;
      else                                  tmo_n   = tmo_q + TW'(1);
    end

    if (fall) begin
      case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end else begin
            err_n = 1'b1;
            ext_n = 1'b0;
            brk_n = 1'b0;
          end
        end
        DATA: begin
          shift_n   = {data_s, shift_q[7:1]};
          bit_cnt_n = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_ok_n = odd_parity_ok(shift_q, data_s);
          state_n  = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (data_s && par_ok_q) begin
            if (shift_q == PS2_PREFIX_EXT) begin
              ext_n = 1'b1;
            end else if (shift_q == PS2_PREFIX_BRK) begin
              brk_n = 1'b1;
            end else begin
              code_n  = shift_q;
              kbrk_n  = brk_q;
              kext_n  = ext_q;
              valid_n = 1'b1;
              ext_n   = 1'b0;
              brk_n   = 1'b0;
            end
          end else begin
            err_n = 1'b1;
            ext_n = 1'b0;
            brk_n = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (timeout) begin
      state_n = IDLE;
      err_n   = 1'b1;
      ext_n   = 1'b0;
      brk_n   = 1'b0;
    end
  end

  assign bus.key_code   = code_q;
  assign bus.key_break  = kbrk_q;
  assign bus.key_ext    = kext_q;
  assign bus.code_valid = valid_q;
  assign bus.frame_err  = err_q;

endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

PS/2 keyboard receiver that deserializes device-to-host frames from the raw `ps2_clk`/`ps2_data` pins, checks the frame, and folds the `E0`/`F0` prefixes into flags. It emits one complete key event per make or break code. It sits directly upstream of the binary-to-BCD/7-segment display path, and `key_code` is the 8-bit value that path displays.

## Interface
- `SYNC_STAGES`, default 2: flops in each pin synchronizer (at least 2).
- `FILTER_LEN`, default 8: number of consecutive equal samples needed before the filtered `ps2_clk` changes state.
- `TIMEOUT_CYCLES`, default 50000: idle `clk` cycles allowed mid-frame before the frame is abandoned (1 ms at 50 MHz).
- `clk` input 1: system clock. One clock domain.
- `rst_n` input 1: reset, asynchronous and active-low.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data` input 1: raw PS/2 data pin, asynchronous to `clk`.
- `key_code` output 8: last reported scan code, held until the next event.
- `key_break` output 1: `key_code` is a release (`F0` prefix seen). Valid alongside `key_code`.
- `key_ext` output 1: `key_code` is extended (`E0` prefix seen). Valid alongside `key_code`.
- `code_valid` output 1: one-cycle pulse when a new key event is on the outputs.
- `frame_err` output 1: one-cycle pulse on a start, parity or stop error, or on a timeout.

## Operation
- Both pins pass through `SYNC_STAGES` flops.
- The synchronized `ps2_clk` feeds a saturating counter filter. The filtered level flips only after `FILTER_LEN` consecutive opposite samples. The filter resets to 1.
- A falling edge of the filtered clock gives a one-cycle `fall` strobe. Data is sampled on `fall` only.
- FSM states are IDLE, DATA, PARITY and STOP.
  - IDLE, on `fall`: data=0 goes to DATA with the bit count cleared. Data=1 is a bad start: pulse `frame_err` and stay in IDLE.
  - DATA, on `fall`: shift the bit in LSB-first. After the 8th bit, go to PARITY.
  - PARITY, on `fall`: check odd parity across the 8 data bits plus the parity bit, latch the result, and go to STOP.
  - STOP, on `fall`: if stop=1 and parity is good, the byte is accepted. Otherwise pulse `frame_err`. Either way, return to IDLE.
- Accepted-byte handling:
  - `E0` sets the internal `ext_pend` flag. No output event.
  - `F0` sets the internal `brk_pend` flag. No output event.
  - Any other byte: `key_code`←byte, `key_break`←`brk_pend`, `key_ext`←`ext_pend`, pulse `code_valid`, then clear both pending flags.
- Errors (`frame_err`) clear both pending flags, so a corrupted sequence never tags a later code.
- Timeout: a counter is cleared on every `fall` and counts while the FSM is outside IDLE. When it reaches `TIMEOUT_CYCLES`, go to IDLE, pulse `frame_err` and clear the pending flags.
- Simultaneous events: if the timeout and `fall` fall in the same cycle, `fall` wins and the counter clears.
- Reset, including mid-frame:
  - All outputs go to 0.
  - FSM goes to IDLE, and the shift register, bit count, pending flags and timeout counter clear.
  - The filter goes to 1 and synchronizer flops go to 1.
  - A partial frame in progress is discarded silently, with no `frame_err`.

## Timing
- Reset values: `key_code`=8'h00, `key_break`=0, `key_ext`=0, `code_valid`=0, `frame_err`=0.
- Latency, counted from the raw stop-bit falling edge on `ps2_clk` to `code_valid`: SYNC_STAGES + FILTER_LEN + 1 `clk` cycles (±1 for sampling phase).
- `code_valid` and `frame_err` are high for exactly one cycle. They are never asserted together.
- `key_code`, `key_break` and `key_ext` all update in the same cycle `code_valid` rises, then hold.
- There is no back-pressure. A consumer must take the event in the `code_valid` cycle.
- PS/2 bit period is at least 60 µs, so `FILTER_LEN` must stay well below half a period at the `clk` rate.

## Structure
- Package `ps2_pkg`:
  - state enum `ps2_state_t` (IDLE, DATA, PARITY, STOP)
  - constants `PS2_PREFIX_EXT`=8'hE0 and `PS2_PREFIX_BRK`=8'hF0
- Sub-module `ps2_in_filter` holds the two synchronizers, the `ps2_clk` glitch filter and the `fall` strobe. Its outputs are `fall` and the synchronized data bit.
- FSM, prefix logic and timeout live in `ps2_scancode_rx`.

## Test plan
- Frame `1C`: bits 0, then 0,0,1,1,1,0,0,0, then parity 0, then stop 1. Expect one `code_valid` with `key_code`=1C, `key_break`=0, `key_ext`=0, and no `frame_err`.
- Frames `F0`,`1C`: exactly one `code_valid`, with `key_code`=1C and `key_break`=1. No event for `F0`.
- Frames `E0`,`F0`,`75`: one event, with `key_code`=75, `key_break`=1 and `key_ext`=1. A following plain `75` then reports `key_break`=0 and `key_ext`=0.
- Two error cases:
  - `F0` followed by `1C` with parity bit 1: `frame_err` pulses and there is no `code_valid`. A following good `1C` reports `key_break`=0.
  - `1C` with stop bit 0: `frame_err` pulses.
- Start bit plus 4 data bits, then `ps2_clk` idle for more than TIMEOUT_CYCLES: `frame_err` pulses once. A following full `32` frame reports `key_code`=32.
- Two robustness cases:
  - A low glitch of FILTER_LEN−1 cycles on `ps2_clk` is ignored, and the frame still decodes correctly.
  - Asserting `rst_n` after 5 bits gives all outputs 0 and no `frame_err`, and the next full frame decodes.
